// File: rtl/decoder_2a4_seq.sv
// Sequential 2-to-4 decoder: accepts a 2-bit code over valid/ready,
// drives the one-hot line for HOLD cycles, then idles for GAP cycles.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   y      code to decode (n drives x[n])
//   v      code valid, accepted only while rdy=1
//   clr    synchronous clear of drops
//   rdy    block can accept a code this cycle (decoded from state)
//   x      registered one-hot output, zero when inactive
//   act    registered flag: x carries a valid one-hot value
//   drops  registered saturating count of v=1 cycles refused
module decoder_2a4_seq #(
    parameter int HOLD = 4,
    parameter int GAP  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] y,
    input  logic       v,
    input  logic       clr,
    output logic       rdy,
    output logic [3:0] x,
    output logic       act,
    output logic [7:0] drops
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // Counter load values; the counter runs down to zero, so a
    // phase of N cycles loads N-1.
    localparam logic [7:0] HOLD_LD = 8'(HOLD - 1);
    localparam logic [7:0] GAP_LD  = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] code_q, code_d;
    logic [3:0] x_q, x_d;
    logic       act_q, act_d;
    logic [7:0] drops_q, drops_d;

    // Ready depends on the state register only, never on v.
    assign rdy   = (state_q == S_IDLE);
    assign x     = x_q;
    assign act   = act_q;
    assign drops = drops_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        case (state_q)
            S_IDLE: begin
                if (v) begin
                    code_d  = y;
                    cnt_d   = HOLD_LD;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else if (GAP > 0) begin
                    cnt_d   = GAP_LD;
                    state_d = S_GAP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                cnt_d   = 8'd0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so that x and act
    // line up with the state they describe, one cycle after accept.
    always_comb begin
        act_d = (state_d == S_HOLD);
        x_d   = 4'b0000;
        if (act_d) begin
            x_d = 4'b0001 << code_d;
        end
    end

    // Clear beats a simultaneous refusal; the count never wraps.
    always_comb begin
        drops_d = drops_q;
        if (clr) begin
            drops_d = 8'd0;
        end else if (v && !rdy && drops_q != 8'hFF) begin
            drops_d = drops_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            code_q  <= 2'd0;
            x_q     <= 4'b0000;
            act_q   <= 1'b0;
            drops_q <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            x_q     <= x_d;
            act_q   <= act_d;
            drops_q <= drops_d;
        end
    end

endmodule

// File: tb/tb_decoder_2a4_seq.sv
// Bench for decoder_2a4_seq: two instances (HOLD=4/GAP=1, HOLD=1/GAP=0)
// checked each cycle against a cycles-since-accept reference model.
module tb_decoder_2a4_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] ya = 2'd0, yb = 2'd0;
    logic       va = 1'b0, vb = 1'b0;
    logic       clra = 1'b0, clrb = 1'b0;
    logic       rdya, rdyb, acta, actb;
    logic [3:0] xa, xb;
    logic [7:0] dropsa, dropsb;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;
    bit rand_b = 1'b0;

    always #5 clk = ~clk;

    decoder_2a4_seq #(.HOLD(4), .GAP(1)) u_a (
        .clk(clk), .rst_n(rst_n), .y(ya), .v(va), .clr(clra),
        .rdy(rdya), .x(xa), .act(acta), .drops(dropsa)
    );

    decoder_2a4_seq #(.HOLD(1), .GAP(0)) u_b (
        .clk(clk), .rst_n(rst_n), .y(yb), .v(vb), .clr(clrb),
        .rdy(rdyb), .x(xb), .act(actb), .drops(dropsb)
    );

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t",
                     name, got, want, $time);
        end
    endtask

    // Reference model: k = cycles since the last accepted code
    // (1000 = long idle). Active while 1<=k<=H, ready once k>H+G.
    int         ka = 1000, kb = 1000;
    int         da = 0, db = 0;
    logic [1:0] ca = 2'd0, cb = 2'd0;

    task automatic step(inout int k, inout logic [1:0] c,
                        inout int d, input int h, input int g,
                        input logic v, input logic [1:0] y,
                        input logic clr);
        bit ok;
        ok = (k > h + g);
        if (clr) d = 0;
        else if (v && !ok && d < 255) d = d + 1;
        if (v && ok) begin
            k = 1;
            c = y;
        end else if (k < 1000) begin
            k = k + 1;
        end
    endtask

    function automatic logic [31:0] exp_x(int k, int h, logic [1:0] c);
        logic [3:0] one;
        one = 4'b0001;
        if (k >= 1 && k <= h) return 32'(one << c);
        return 32'd0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ka = 1000; kb = 1000;
            da = 0;    db = 0;
            ca = 2'd0; cb = 2'd0;
        end else begin
            step(ka, ca, da, 4, 1, va, ya, clra);
            step(kb, cb, db, 1, 0, vb, yb, clrb);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("a_x", 32'(xa), exp_x(ka, 4, ca));
            chk("a_act", 32'(acta), 32'(ka >= 1 && ka <= 4));
            chk("a_rdy", 32'(rdya), 32'(ka > 5));
            chk("a_drops", 32'(dropsa), 32'(da));
            chk("a_onehot", 32'($countones(xa)), 32'(acta));
            chk("b_x", 32'(xb), exp_x(kb, 1, cb));
            chk("b_act", 32'(actb), 32'(kb == 1));
            chk("b_rdy", 32'(rdyb), 32'(kb > 1));
            chk("b_drops", 32'(dropsb), 32'(db));
            chk("b_onehot", 32'($countones(xb)), 32'(actb));
        end
    end

    // Instance B: v held high with a wandering code, later random.
    always @(negedge clk) begin
        yb = 2'($urandom_range(0, 3));
        if (rand_b) begin
            vb   = 1'($urandom_range(0, 1));
            clrb = ($urandom_range(0, 31) == 0);
        end else begin
            vb   = 1'b1;
            clrb = 1'b0;
        end
    end

    task automatic wait_rdy();
        int n;
        n = 0;
        while (!rdya && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("a_rdy_wait", 32'(rdya), 32'd1);
    endtask

    initial begin
        int cyc0, cyc1, acc_n, acc_bad, r, n, ones;
        logic prev;

        // Reset state
        #2;
        chk("rst_rdy", 32'(rdya), 32'd1);
        chk("rst_x", 32'(xa), 32'd0);
        chk("rst_act", 32'(acta), 32'd0);
        chk("rst_drops", 32'(dropsa), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        cmp_en = 1'b1;

        // Single code y=2
        va = 1'b1; ya = 2'd2;
        @(negedge clk);
        va = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            if (i > 1) @(negedge clk);
            if (i <= 4) begin
                chk("t1_x", 32'(xa), 32'h4);
                chk("t1_act", 32'(acta), 32'd1);
                chk("t1_rdy", 32'(rdya), 32'd0);
            end else if (i == 5) begin
                chk("t1_gap_x", 32'(xa), 32'd0);
                chk("t1_gap_rdy", 32'(rdya), 32'd0);
            end else begin
                chk("t1_rdy_back", 32'(rdya), 32'd1);
            end
        end
        chk("t1_drops", 32'(dropsa), 32'd0);

        // Sweep codes, spacing must be HOLD+GAP+1 = 6
        cyc0 = 0;
        for (int c = 0; c < 4; c++) begin
            wait_rdy();
            cyc1 = int'($time / 10);
            if (c > 0) chk("t2_spacing", 32'(cyc1 - cyc0), 32'd6);
            cyc0 = cyc1;
            va = 1'b1; ya = 2'(c);
            @(negedge clk);
            va = 1'b0;
            chk("t2_x", 32'(xa), 32'(1 << c));
            @(negedge clk);
        end

        // v held with y=3 for 20 cycles
        wait_rdy();
        acc_n = 0; acc_bad = 0;
        va = 1'b1; ya = 2'd3;
        for (int i = 0; i < 20; i++) begin
            if (rdya) begin
                acc_n++;
                if (i % 6 != 0) acc_bad++;
            end
            @(negedge clk);
        end
        va = 1'b0;
        chk("t3_accepts", 32'(acc_n), 32'd4);
        chk("t3_spacing", 32'(acc_bad), 32'd0);
        chk("t3_drops", 32'(dropsa), 32'd16);

        // Instance B: 1-cycle pulse alternating with idle
        prev = actb;
        ones = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("tb_alt", 32'(actb ^ prev), 32'd1);
            prev = actb;
            if (actb) ones++;
        end
        chk("tb_pulses", 32'(ones), 32'd5);

        // Saturation then clear on a refused cycle
        r = 0; n = 0;
        va = 1'b1;
        while (r < 300 && n < 2000) begin
            if (!rdya) r++;
            @(negedge clk);
            n++;
        end
        chk("t5_refused", 32'(r), 32'd300);
        chk("t5_sat", 32'(dropsa), 32'd255);
        while (rdya && n < 2100) begin
            @(negedge clk);
            n++;
        end
        chk("t5_busy", 32'(rdya), 32'd0);
        clra = 1'b1;
        @(negedge clk);
        clra = 1'b0;
        va = 1'b0;
        chk("t5_clr", 32'(dropsa), 32'd0);

        // Async reset in second HOLD cycle of y=1
        wait_rdy();
        va = 1'b1; ya = 2'd1;
        @(negedge clk);
        va = 1'b0;
        chk("t6_x1", 32'(xa), 32'h2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_x", 32'(xa), 32'd0);
        chk("t6_rst_act", 32'(acta), 32'd0);
        chk("t6_rst_rdy", 32'(rdya), 32'd1);
        #1 rst_n = 1'b1;
        @(negedge clk);
        va = 1'b1; ya = 2'd3;
        @(negedge clk);
        va = 1'b0;
        chk("t6_after", 32'(xa), 32'h8);

        // Random traffic on both instances
        rand_b = 1'b1;
        repeat (3000) begin
            @(negedge clk);
            va   = 1'($urandom_range(0, 1));
            ya   = 2'($urandom_range(0, 3));
            clra = ($urandom_range(0, 31) == 0);
        end
        @(negedge clk);
        cmp_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
